xm_mem_responder: RTL and testbench
===================================

XM_MEM_RESPONDER -- requirements
Module: xm_mem_responder

Interface
REQ-001 The block SHALL have parameter WORD, default 16, meaning the data width.
REQ-002 The block SHALL have parameter DEPTH, default 1024, meaning the number of WORD-wide storage locations.
REQ-003 The block SHALL have parameter WAIT_STATES, default 2, meaning the extra busy cycles before an access executes (legal range 0-15).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port arst_i, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port memEn_i, input, 1 bit: access request strobe.
REQ-007 The block SHALL have port memRW_i, input, 1 bit: 0 = read, 1 = write.
REQ-008 The block SHALL have port byteOp_i, input, 1 bit: 1 = byte access, 0 = word access.
REQ-009 The block SHALL have port memAddr_i, input, WORD bits: byte address.
REQ-010 The block SHALL have port memWrData_i, input, WORD bits: write data; a byte write uses bits [7:0].
REQ-011 The block SHALL have port memBusy_o, output, 1 bit: the responder is servicing an access.
REQ-012 The block SHALL have port memRdData_o, output, WORD bits: read result.
REQ-013 The block SHALL have port memRdValid_o, output, 1 bit: a one-cycle completion pulse, for reads and writes.
REQ-014 The block SHALL have port memFault_o, output, 1 bit: a one-cycle fault pulse, coincident with memRdValid_o.

Function
REQ-015 The block SHALL implement states IDLE, WAIT, ACCESS and DONE.
REQ-016 Acceptance: the block SHALL accept a request when memEn_i=1 at a rising edge while in IDLE or DONE, and SHALL register memRW_i, byteOp_i, memAddr_i and memWrData_i on that edge.
REQ-017 Transitions on acceptance: the block SHALL go to WAIT when WAIT_STATES>0, else to ACCESS.
REQ-018 WAIT: the block SHALL stay for exactly WAIT_STATES cycles using a down-counter loaded on acceptance, then go to ACCESS.
REQ-019 ACCESS: the block SHALL spend one cycle, perform the array read or write on its ending edge, then go to DONE.
REQ-020 DONE: the block SHALL spend one cycle, then go to IDLE, or to WAIT/ACCESS if a new request is accepted.
REQ-021 memBusy_o SHALL be 1 exactly in WAIT and ACCESS, and 0 in IDLE and DONE.
REQ-022 memRdValid_o SHALL be 1 exactly in DONE.
REQ-023 Latency: memRdValid_o SHALL rise WAIT_STATES+2 cycles after the acceptance edge.
REQ-024 memEn_i SHALL be ignored while memBusy_o=1, with no queuing.
REQ-025 Word index SHALL be memAddr_i[WORD-1:1].
REQ-026 Byte lane SHALL be memAddr_i[0], little-endian: 0 = bits [7:0], 1 = bits [15:8].
REQ-027 A byte read SHALL return the selected byte zero-extended to WORD bits.
REQ-028 A byte write SHALL modify only the selected lane.
REQ-029 A word write SHALL modify the whole location.
REQ-030 memRdData_o SHALL be updated only on completed reads and SHALL hold its value otherwise, including after writes.
REQ-031 An out-of-range address (word index >= DEPTH) SHALL return 0 on a read and SHALL leave the array unchanged on a write.
REQ-032 A word access with memAddr_i[0]=1 SHALL be handled per REQ-037/REQ-038.
REQ-033 Storage contents SHALL NOT be affected by reset and SHALL power up undefined.

Reset
REQ-034 With arst_i=0 at a rising edge, the block SHALL go to IDLE, clear the wait counter and drive memBusy_o=0, memRdValid_o=0, memFault_o=0 and memRdData_o=0.
REQ-035 A reset during WAIT or ACCESS SHALL abort the access; a pending write SHALL NOT be committed unless its ACCESS ending edge had arst_i=1.
REQ-036 A request presented on the reset edge SHALL be ignored.

Configuration
REQ-037 With macro XM_MEM_FAULT_EN defined, a misaligned word access or an out-of-range access SHALL pulse memFault_o in DONE, perform no array write, and set memRdData_o=0 for reads.
REQ-038 Without XM_MEM_FAULT_EN, memFault_o SHALL be constant 0, misaligned word accesses SHALL ignore memAddr_i[0], and out-of-range accesses SHALL behave per REQ-031.

Verification
REQ-039 With WAIT_STATES=2, write word 0xBEEF to address 0x0010, then read 0x0010: memBusy_o is high for 3 cycles per access, memRdValid_o pulses on the 4th cycle, and memRdData_o=0xBEEF.
REQ-040 Byte-write 0x12 to address 0x0011 over stored 0xBEEF, then word-read 0x0010: the result is 0x12EF; a byte-read of 0x0010 returns 0x00EF.
REQ-041 With WAIT_STATES=0, issue back-to-back reads with memEn_i held high: a request is accepted in every DONE, and memRdValid_o pulses every 2 cycles.
REQ-042 Assert memEn_i during WAIT with a different address: it is ignored, and the original access completes with its own data.
REQ-043 Drive arst_i=0 during ACCESS of a write of 0x5555 over 0xAAAA: afterwards the outputs are 0, the state is IDLE, and a read returns 0xAAAA.
REQ-044 With XM_MEM_FAULT_EN, a word-read at address 0x0003 and a write to word index DEPTH: each pulses memFault_o with memRdValid_o, the read returns 0, and the array is unchanged.

Source files
------------

// File: rtl/xm_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : xm_mem_responder_if
// Description : Request/response bundle between a memory master and
//               xm_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface xm_mem_responder_if #(
  parameter int WORD = 16
);
  logic            memEn_i;
  logic            memRW_i;
  logic            byteOp_i;
  logic [WORD-1:0] memAddr_i;
  logic [WORD-1:0] memWrData_i;
  logic            memBusy_o;
  logic [WORD-1:0] memRdData_o;
  logic            memRdValid_o;
  logic            memFault_o;

  modport slave (
    input  memEn_i,
    input  memRW_i,
    input  byteOp_i,
    input  memAddr_i,
    input  memWrData_i,
    output memBusy_o,
    output memRdData_o,
    output memRdValid_o,
    output memFault_o
  );

  modport master (
    output memEn_i,
    output memRW_i,
    output byteOp_i,
    output memAddr_i,
    output memWrData_i,
    input  memBusy_o,
    input  memRdData_o,
    input  memRdValid_o,
    input  memFault_o
  );
endinterface
`default_nettype wire

// File: rtl/xm_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : xm_mem_responder
// Description : Wait-stated single-port memory responder with byte/word
//               access. Define XM_MEM_FAULT_EN to flag misaligned word and
//               out-of-range accesses on memFault_o.
// Revision    : 1.0 - initial release
// ============================================================================
module xm_mem_responder #(
  parameter int WORD        = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  wire logic         clk_i,
  input  wire logic         arst_i,
  xm_mem_responder_if.slave bus
);

  localparam int         c_aw        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] c_wait_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_wait_cnt;
  logic [3:0]      w_wait_cnt_nxt;
  logic            r_rw;
  logic            r_byte;
  logic [WORD-1:0] r_addr;
  logic [WORD-1:0] r_wdata;
  logic [WORD-1:0] r_rd_data;
  logic [WORD-1:0] r_mem [DEPTH];

  logic            w_accept;
  logic [WORD-2:0] w_word_idx;
  logic [c_aw-1:0] w_mem_idx;
  logic            w_oor;
  logic            w_fault;
  logic            w_blocked;
  logic [WORD-1:0] w_mem_word;
  logic [WORD-1:0] w_rd_value;

  assign w_accept   = bus.memEn_i && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_word_idx = r_addr[WORD-1:1];
  assign w_mem_idx  = w_word_idx[c_aw-1:0];
  assign w_oor      = (32'(w_word_idx) >= 32'(DEPTH));

`ifdef XM_MEM_FAULT_EN
  assign w_fault = w_oor || (!r_byte && r_addr[0]);
`else
  assign w_fault = 1'b0;
`endif

  // Out-of-range indices would alias after truncation, so they are always blocked.
  assign w_blocked  = w_oor || w_fault;
  assign w_mem_word = r_mem[w_mem_idx];

  always_comb begin
    w_rd_value = '0;
    if (!w_blocked) begin
      if (!r_byte) begin
        w_rd_value = w_mem_word;
      end else if (r_addr[0]) begin
        w_rd_value = {{(WORD-8){1'b0}}, w_mem_word[15:8]};
      end else begin
        w_rd_value = {{(WORD-8){1'b0}}, w_mem_word[7:0]};
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nxt = S_IDLE;
        if (w_accept) begin
          w_wait_cnt_nxt = c_wait_load;
          w_state_nxt    = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_state_nxt = S_ACCESS;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        end
      end
      S_ACCESS: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!arst_i) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_rd_data  <= '0;
      r_rw       <= 1'b0;
      r_byte     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_accept) begin
        r_rw    <= bus.memRW_i;
        r_byte  <= bus.byteOp_i;
        r_addr  <= bus.memAddr_i;
        r_wdata <= bus.memWrData_i;
      end
      if ((r_state == S_ACCESS) && !r_rw) begin
        r_rd_data <= w_rd_value;
      end
    end
  end

  // Storage is deliberately unreset; a reset on the ACCESS edge drops the write.
  always_ff @(posedge clk_i) begin
    if (arst_i && (r_state == S_ACCESS) && r_rw && !w_blocked) begin
      if (!r_byte) begin
        r_mem[w_mem_idx] <= r_wdata;
      end else if (r_addr[0]) begin
        r_mem[w_mem_idx][15:8] <= r_wdata[7:0];
      end else begin
        r_mem[w_mem_idx][7:0] <= r_wdata[7:0];
      end
    end
  end

  assign bus.memBusy_o    = (r_state == S_WAIT) || (r_state == S_ACCESS);
  assign bus.memRdValid_o = (r_state == S_DONE);
  assign bus.memFault_o   = (r_state == S_DONE) && w_fault;
  assign bus.memRdData_o  = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_xm_mem_responder.sv
`default_nettype none
// Scoreboarded directed bench for xm_mem_responder (WAIT_STATES=2 main
// instance plus a WAIT_STATES=0 instance for back-to-back streaming).
module tb_xm_mem_responder;

  localparam int WS    = 2;
  localparam int DEPTH = 1024;
`ifdef XM_MEM_FAULT_EN
  localparam bit FLT = 1'b1;
`else
  localparam bit FLT = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic        fault;
  } exp_t;

  logic        clk  = 1'b0;
  logic        arst = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] last_rd = 16'h0000;

  always #5 clk = ~clk;

  xm_mem_responder_if #(.WORD(16)) bus  ();
  xm_mem_responder_if #(.WORD(16)) bus0 ();

  xm_mem_responder #(.WORD(16), .DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk_i  (clk),
    .arst_i (arst),
    .bus    (bus)
  );

  xm_mem_responder #(.WORD(16), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk_i  (clk),
    .arst_i (arst),
    .bus    (bus0)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (arst === 1'b1 && bus.memRdValid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got completion, expected none (rd_data %h)", bus.memRdData_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("rd_data", bus.memRdData_o, mon_e.data);
        check("fault", {15'b0, bus.memFault_o}, {15'b0, mon_e.fault});
      end
    end else if (arst === 1'b1 && bus.memFault_o !== 1'b0) begin
      check("stray_fault", {15'b0, bus.memFault_o}, 16'h0000);
    end
  end

  // Called at a negedge with the DUT in IDLE or DONE; returns at the DONE negedge.
  task automatic access(input logic rw, input logic bt, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [15:0] rd_exp,
                        input logic flt, input bit poke, input bit abort);
    int k;
    int nbusy;
    bus.memEn_i     = 1'b1;
    bus.memRW_i     = rw;
    bus.byteOp_i    = bt;
    bus.memAddr_i   = addr;
    bus.memWrData_i = wd;
    @(posedge clk);
    if (!abort) begin
      if (!rw) last_rd = rd_exp;
      exp_q.push_back(exp_t'{data: last_rd, fault: flt});
    end
    nbusy = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.memEn_i   = poke;
        bus.memAddr_i = addr ^ 16'h0100;
      end
      if (k == 2) bus.memEn_i = 1'b0;
      if (abort && k == WS + 1) begin
        arst = 1'b0;
        @(negedge clk);
        check("abort_busy",    {15'b0, bus.memBusy_o},    16'h0000);
        check("abort_valid",   {15'b0, bus.memRdValid_o}, 16'h0000);
        check("abort_fault",   {15'b0, bus.memFault_o},   16'h0000);
        check("abort_rd_data", bus.memRdData_o,           16'h0000);
        arst    = 1'b1;
        last_rd = 16'h0000;
        return;
      end
      if (bus.memRdValid_o === 1'b1) break;
      if (bus.memBusy_o === 1'b1) nbusy++;
    end
    check("latency",     16'(k),     16'(WS + 2));
    check("busy_cycles", 16'(nbusy), 16'(WS + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.memEn_i      = 1'b1;
    bus.memRW_i      = 1'b0;
    bus.byteOp_i     = 1'b0;
    bus.memAddr_i    = 16'h0010;
    bus.memWrData_i  = 16'h0000;
    bus0.memEn_i     = 1'b0;
    bus0.memRW_i     = 1'b0;
    bus0.byteOp_i    = 1'b0;
    bus0.memAddr_i   = 16'h0000;
    bus0.memWrData_i = 16'h0000;
    arst = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy",    {15'b0, bus.memBusy_o},    16'h0000);
    check("rst_valid",   {15'b0, bus.memRdValid_o}, 16'h0000);
    check("rst_fault",   {15'b0, bus.memFault_o},   16'h0000);
    check("rst_rd_data", bus.memRdData_o,           16'h0000);
    arst        = 1'b1;
    bus.memEn_i = 1'b0;
    @(negedge clk);
    check("rst_req_ignored", {15'b0, bus.memBusy_o}, 16'h0000);

    // Zero-wait instance: write, then reads with enable held high.
    bus0.memEn_i     = 1'b1;
    bus0.memRW_i     = 1'b1;
    bus0.memAddr_i   = 16'h0004;
    bus0.memWrData_i = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    bus0.memRW_i = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      check("b2b_valid", {15'b0, bus0.memRdValid_o}, {15'b0, (k % 2 == 0)});
      check("b2b_busy",  {15'b0, bus0.memBusy_o},    {15'b0, (k % 2 != 0)});
      if (k % 2 == 0) check("b2b_data", bus0.memRdData_o, (k == 2) ? 16'h0000 : 16'h1234);
    end
    bus0.memEn_i = 1'b0;
    @(negedge clk);

    //     rw    bt    addr      wdata     rd_exp                   flt   poke abort
    access(1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000,                1'b0, 0, 0);
    access(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF,                1'b0, 0, 0);
    access(1'b1, 1'b1, 16'h0011, 16'h3412, 16'h0000,                1'b0, 0, 0);
    access(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h12EF,                1'b0, 0, 0);
    access(1'b0, 1'b1, 16'h0010, 16'h0000, 16'h00EF,                1'b0, 0, 0);
    access(1'b0, 1'b1, 16'h0011, 16'h0000, 16'h0012,                1'b0, 0, 0);
    access(1'b1, 1'b1, 16'h0010, 16'hAB77, 16'h0000,                1'b0, 0, 0);
    access(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1277,                1'b0, 1, 0);
    access(1'b1, 1'b0, 16'h0002, 16'h5A5A, 16'h0000,                1'b0, 0, 0);
    access(1'b0, 1'b0, 16'h0003, 16'h0000, FLT ? 16'h0000 : 16'h5A5A, FLT, 0, 0);
    access(1'b1, 1'b0, 16'h0012, 16'h0101, 16'h0000,                1'b0, 0, 0);
    access(1'b1, 1'b0, 16'h0013, 16'hCAFE, 16'h0000,                FLT,  0, 0);
    access(1'b0, 1'b0, 16'h0012, 16'h0000, FLT ? 16'h0101 : 16'hCAFE, 1'b0, 0, 0);
    access(1'b1, 1'b0, 16'h0000, 16'h4242, 16'h0000,                1'b0, 0, 0);
    access(1'b1, 1'b0, 16'h0800, 16'h9999, 16'h0000,                FLT,  0, 0);
    access(1'b0, 1'b0, 16'h0800, 16'h0000, 16'h0000,                FLT,  0, 0);
    access(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h4242,                1'b0, 0, 0);
    access(1'b1, 1'b0, 16'h0020, 16'hAAAA, 16'h0000,                1'b0, 0, 0);
    access(1'b0, 1'b0, 16'h0020, 16'h0000, 16'hAAAA,                1'b0, 0, 0);
    access(1'b1, 1'b0, 16'h0020, 16'h5555, 16'h0000,                1'b0, 0, 1);
    check("post_abort_idle", {15'b0, bus.memBusy_o}, 16'h0000);
    access(1'b0, 1'b0, 16'h0020, 16'h0000, 16'hAAAA,                1'b0, 0, 0);

    bus.memEn_i = 1'b0;
    repeat (5) @(negedge clk);
    check("sb_empty", 16'(exp_q.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
